// File: rtl/seq_mult16_pkg.sv
// Shared definitions for the sequential 16x16 shift-and-add multiplier.
package seq_mult16_pkg;

   // Operand width supported by the fixed-width partial-product adder.
   localparam int OP_W       = 16;
   // Number of shift-and-add iterations per operation.
   localparam int ITER_COUNT = 16;
   // Iteration counter width: wide enough to hold ITER_COUNT without wrapping.
   localparam int CNT_W      = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True on the RUN cycle whose edge completes the final iteration.
   function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
      return cnt == CNT_W'(ITER_COUNT - 1);
   endfunction

endpackage

// File: rtl/seq_mult16_adder16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// group-level carry chain. Purely combinational.
module adder16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] s_o,
   output logic        cout_o,
   output logic        p_o
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:0]  gc;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Group generate/propagate, group carries, then in-group carries.
   always_comb begin
      gg = '0;
      gp = '0;
      gc = '0;
      c  = '0;
      gc[0] = cin_i;
      for (int j = 0; j < 4; j++) begin
         gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
         c[4*j] = gc[j];
         for (int k = 0; k < 3; k++) begin
            c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
         end
      end
   end

   assign s_o    = p ^ c;
   assign cout_o = gc[4];
   assign p_o    = &gp;

endmodule

// File: rtl/seq_mult16.sv
// Sequential unsigned 16x16 shift-and-add multiplier. One adder16 is reused
// for 16 iterations; the 33-bit {carry,sum,multiplier} value is shifted right
// once per RUN cycle so the product accumulates in {acc,mq}.
module seq_mult16
   import seq_mult16_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   if (WIDTH != OP_W) begin : g_width_check
      $error("seq_mult16: WIDTH must be 16, adder16 is fixed-width");
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mq_q, mq_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   sum;
   logic               cout;

   // Multiplicand is added only when the current multiplier LSB is set.
   assign add_b = mq_q[0] ? mcand_q : '0;

   adder16 u_adder16 (
      .a_i    (acc_q),
      .b_i    (add_b),
      .cin_i  (1'b0),
      .s_o    (sum),
      .cout_o (cout),
      .p_o    ()
   );

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      mcand_d   = mcand_q;
      count_d   = count_q;
      product_d = product_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               mcand_d = a;
               acc_d   = '0;
               mq_d    = b;
               count_d = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Carry goes into acc MSB so no bit of the partial sum is lost.
            acc_d   = {cout, sum[WIDTH-1:1]};
            mq_d    = {sum[0], mq_q[WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
            if (is_last_iter(count_q)) begin
               product_d = {acc_d, mq_d};
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         mq_q      <= '0;
         mcand_q   <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         mcand_q   <= mcand_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign ready   = (state_q == ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_seq_mult16.sv
// Scoreboard bench for seq_mult16: the driver pushes expected product and
// accept edge; a negedge monitor pops on every done pulse and compares.
module tb_seq_mult16;

   typedef struct {
      logic [31:0] prod;
      int          acc_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        ready;
   logic        done;
   logic [31:0] product;

   int   cyc    = 0;
   int   npass  = 0;
   int   ntot   = 0;
   bit   mon_en = 1'b0;
   exp_t sb[$];

   seq_mult16 #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: pop and compare on each done pulse; check done/ready exclusivity.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("done_ready_exclusive", {31'b0, done & ready}, 32'h0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'h1, 32'h0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("product", product, e.prod);
               chk("done_latency", 32'(cyc - e.acc_cyc), 32'd16);
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("ready_timeout", 32'h0, 32'h1);
   endtask

   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ex);
      wait_ready();
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back('{prod: ex, acc_cyc: cyc});
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
   endtask

   initial begin
      int e;
      int n;
      logic [15:0] ra;
      logic [15:0] rb;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      chk("reset_ready", {31'b0, ready}, 32'h1);
      chk("reset_done", {31'b0, done}, 32'h0);
      chk("reset_product", product, 32'h0);

      // Basic product, latency, and ready returning after the done pulse.
      issue(16'h1234, 16'h5678, 32'h0626_0060);
      n = 0;
      @(negedge clk);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t1_done_seen", {31'b0, done}, 32'h1);
      @(negedge clk);
      chk("t1_ready_after_done", {31'b0, ready}, 32'h1);

      // Operand corner cases.
      issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
      issue(16'h0000, 16'hFFFF, 32'h0000_0000);
      issue(16'h8000, 16'h0002, 32'h0001_0000);
      issue(16'h0001, 16'hFFFF, 32'h0000_FFFF);

      // start held high through RUN must not restart or queue an operation.
      wait_ready();
      a = 16'd3; b = 16'd5; start = 1'b1;
      @(posedge clk);
      #1;
      e = cyc;
      sb.push_back('{prod: 32'h0000_000F, acc_cyc: e});
      a = 16'hFFFF; b = 16'hFFFF;
      repeat (16) @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t3_ready_idle", {31'b0, ready}, 32'h1);
      chk("t3_product_held", product, 32'h0000_000F);

      // Reset mid-operation aborts with no done and clears product.
      wait_ready();
      a = 16'h00FF; b = 16'h0100; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t4_ready_after_rst", {31'b0, ready}, 32'h1);
      chk("t4_product_after_rst", product, 32'h0);
      chk("t4_done_after_rst", {31'b0, done}, 32'h0);
      repeat (12) @(negedge clk);
      issue(16'd7, 16'd9, 32'h0000_003F);

      // rst and start on the same edge: start is dropped.
      wait_ready();
      rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222;
      @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_start_ready", {31'b0, ready}, 32'h1);
      chk("rst_start_product", product, 32'h0);

      // Back-to-back with start held continuously; product holds between.
      wait_ready();
      a = 16'd2; b = 16'd3; start = 1'b1;
      @(posedge clk);
      #1;
      e = cyc;
      sb.push_back('{prod: 32'h0000_0006, acc_cyc: e});
      sb.push_back('{prod: 32'h0000_0014, acc_cyc: e + 18});
      a = 16'd4; b = 16'd5;
      repeat (34) begin
         @(negedge clk);
         if (cyc == e + 18) start = 1'b0;
         if (cyc >= e + 17 && cyc <= e + 33) chk("t5_product_hold", product, 32'h0000_0006);
      end

      // Random operands against a behavioural multiply.
      for (int i = 0; i < 2000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         issue(ra, rb, 32'(ra) * 32'(rb));
      end

      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
